// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multicycle multiply/divide unit.
package muldiv_pkg;

   // Operation code carried on Op, sampled together with Start.
   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } muldiv_op_e;

   // Sequencer states: idle, shift-add multiply, restoring divide, sign fix-up.
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_MUL  = 2'b01,
      S_DIV  = 2'b10,
      S_FIX  = 2'b11
   } muldiv_state_e;

   // Divide-by-zero quotient is this bit replicated across Lo (all ones).
   localparam logic DIV_ZERO_FILL = 1'b1;

endpackage

// File: rtl/muldiv_unit_if.sv
// Control-unit side bus of the multiply/divide unit.
//
// Handshake: Start is sampled only while Busy = 0 (IDLE); an accepted Start
// raises Busy on the next edge. Busy stays high until the edge that writes
// Hi/Lo, on which Done pulses high for exactly one cycle. Start while Busy is
// dropped, never queued. Abort ends an operation without a Done pulse.
interface muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             Start;
   logic [1:0]       Op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Abort;
   logic             HiWrite;
   logic             LoWrite;
   logic [WIDTH-1:0] WrData;
   logic             Busy;
   logic             Done;
   logic             DivZero;
   logic [WIDTH-1:0] Hi;
   logic [WIDTH-1:0] Lo;

   modport master (
      output Start, Op, A, B, Abort, HiWrite, LoWrite, WrData,
      input  Busy, Done, DivZero, Hi, Lo
   );

   modport slave (
      input  Start, Op, A, B, Abort, HiWrite, LoWrite, WrData,
      output Busy, Done, DivZero, Hi, Lo
   );
endinterface

// File: rtl/muldiv_unit_magnitude_conv.sv
// Converts an optionally signed operand into magnitude plus sign flag.
module magnitude_conv #(
   parameter int WIDTH = 32
) (
   input  logic             is_signed,
   input  logic [WIDTH-1:0] value,
   output logic [WIDTH-1:0] magnitude,
   output logic             negative
);
   // The most negative value maps onto itself, which is the correct unsigned magnitude.
   assign negative  = is_signed & value[WIDTH-1];
   assign magnitude = negative ? -value : value;
endmodule

// File: rtl/muldiv_unit.sv
// Multicycle multiply/divide unit with HI/LO result registers.
// One 2*WIDTH+1 shift register is shared by shift-add multiply and
// restoring divide; sign correction is applied once in FIX.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic          Clk,
   input  logic          Reset,
   muldiv_unit_if.slave  bus,
   output muldiv_state_e dbg_state
);
   localparam int CW = $clog2(WIDTH + 1);

   muldiv_state_e    state, next_state;
   muldiv_op_e       op_q;
   logic [CW-1:0]    cnt;
   logic [2*WIDTH:0] sreg;
   logic [WIDTH-1:0] dsr;
   logic             res_neg, dvd_neg, zero_q;
   logic             busy_q, done_q, dz_q;
   logic [WIDTH-1:0] hi_q, lo_q;

   muldiv_op_e       start_op;
   logic             op_signed, op_div, b_zero, abort_now;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic             a_neg, b_neg;

   logic [WIDTH-1:0]   addend;
   logic [WIDTH:0]     mul_sum, rem_shift, rem_sub;
   logic               rem_ge;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0]   quo, rem, quo_fix, rem_fix;

   assign start_op  = muldiv_op_e'(bus.Op);
   assign op_signed = (start_op == OP_MULT) || (start_op == OP_DIV);
   assign op_div    = (start_op == OP_DIV) || (start_op == OP_DIVU);
   assign b_zero    = (bus.B == '0);
   assign abort_now = bus.Abort && (state != S_IDLE);

   magnitude_conv #(.WIDTH(WIDTH)) u_mag_a (
      .is_signed(op_signed), .value(bus.A), .magnitude(a_mag), .negative(a_neg)
   );
   magnitude_conv #(.WIDTH(WIDTH)) u_mag_b (
      .is_signed(op_signed), .value(bus.B), .magnitude(b_mag), .negative(b_neg)
   );

   // Multiply step: add multiplicand when the current multiplier bit is set.
   assign addend  = sreg[0] ? dsr : '0;
   assign mul_sum = sreg[2*WIDTH:WIDTH] + {1'b0, addend};

   // Divide step: shift next dividend bit into the remainder, trial-subtract.
   assign rem_shift = {sreg[2*WIDTH-1:WIDTH], sreg[WIDTH-1]};
   assign rem_ge    = (rem_shift >= {1'b0, dsr});
   assign rem_sub   = rem_shift - {1'b0, dsr};

   // Sign fix-up applied on the FIX edge.
   assign prod     = sreg[2*WIDTH-1:0];
   assign quo      = sreg[WIDTH-1:0];
   assign rem      = sreg[2*WIDTH-1:WIDTH];
   assign prod_fix = res_neg ? -prod : prod;
   assign quo_fix  = res_neg ? -quo : quo;
   assign rem_fix  = dvd_neg ? -rem : rem;

   // State register.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) state <= S_IDLE;
      else        state <= next_state;
   end

   // Next-state logic; abort overrides every in-flight transition.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: if (bus.Start) next_state = op_div ? (b_zero ? S_FIX : S_DIV) : S_MUL;
         S_MUL,
         S_DIV:  if (cnt == CW'(1)) next_state = S_FIX;
         S_FIX:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
      if (abort_now) next_state = S_IDLE;
   end

   // Datapath, result registers and status flags.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         op_q    <= OP_MULT;
         cnt     <= '0;
         sreg    <= '0;
         dsr     <= '0;
         res_neg <= 1'b0;
         dvd_neg <= 1'b0;
         zero_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         done_q <= 1'b0;
         if (abort_now) begin
            busy_q <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (bus.HiWrite) hi_q <= bus.WrData;
                  if (bus.LoWrite) lo_q <= bus.WrData;
                  if (bus.Start) begin
                     op_q    <= start_op;
                     // Multiply keeps |B| in the low half and |A| aside; divide the reverse.
                     // Divide by zero parks the raw dividend so FIX can return it in Hi.
                     sreg    <= {{(WIDTH+1){1'b0}},
                                 op_div ? (b_zero ? bus.A : a_mag) : b_mag};
                     dsr     <= op_div ? b_mag : a_mag;
                     res_neg <= a_neg ^ b_neg;
                     dvd_neg <= a_neg;
                     zero_q  <= op_div && b_zero;
                     dz_q    <= 1'b0;
                     cnt     <= CW'(WIDTH);
                     busy_q  <= 1'b1;
                  end
               end
               S_MUL: begin
                  sreg <= {1'b0, mul_sum, sreg[WIDTH-1:1]};
                  cnt  <= cnt - CW'(1);
               end
               S_DIV: begin
                  sreg <= {(rem_ge ? rem_sub : rem_shift), sreg[WIDTH-2:0], rem_ge};
                  cnt  <= cnt - CW'(1);
               end
               S_FIX: begin
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  if (zero_q) begin
                     hi_q <= sreg[WIDTH-1:0];
                     lo_q <= {WIDTH{DIV_ZERO_FILL}};
                     dz_q <= 1'b1;
                  end else if ((op_q == OP_MULT) || (op_q == OP_MULTU)) begin
                     {hi_q, lo_q} <= prod_fix;
                  end else begin
                     hi_q <= rem_fix;
                     lo_q <= quo_fix;
                  end
               end
               default: busy_q <= 1'b0;
            endcase
         end
      end
   end

   assign bus.Busy    = busy_q;
   assign bus.Done    = done_q;
   assign bus.DivZero = dz_q;
   assign bus.Hi      = hi_q;
   assign bus.Lo      = lo_q;
   assign dbg_state   = state;
endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: scenario tasks with a queue of expected {Hi,Lo}.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   muldiv_state_e dbg_state;

   muldiv_unit_if #(.WIDTH(W)) dut_if ();

   muldiv_unit #(.WIDTH(W)) dut (
      .Clk(clk), .Reset(rst_n), .bus(dut_if.slave), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   logic [2*W-1:0] exp_q[$];
   logic [2*W-1:0] exp_v;
   logic [2*W-1:0] last_exp;
   int n_cmp = 0;
   int n_fail = 0;
   int edges, busy_cyc, n_done;
   bit seen;

   // Reference model built from native SV arithmetic.
   function automatic logic [2*W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
      longint sa, sb, q, r;
      longint unsigned ua, ub, uq, ur;
      logic [2*W-1:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      res = '0;
      if (op[1] && (b == '0)) begin
         res = {a, {W{1'b1}}};
      end else begin
         case (op)
            2'b00: res = sa * sb;
            2'b01: res = ua * ub;
            2'b10: begin q = sa / sb; r = sa % sb; res = {r[W-1:0], q[W-1:0]}; end
            default: begin uq = ua / ub; ur = ua % ub; res = {ur[W-1:0], uq[W-1:0]}; end
         endcase
      end
      return res;
   endfunction

   // Driver: present Start for one edge and record the expected result.
   task automatic issue_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      dut_if.Start = 1'b1;
      dut_if.Op    = op;
      dut_if.A     = a;
      dut_if.B     = b;
      exp_q.push_back(model(op, a, b));
      @(posedge clk);
      #1;
      dut_if.Start = 1'b0;
   endtask

   // Bounded wait for Done; called 1 time unit after the Start edge.
   task automatic wait_done(output int e, output int bc, output bit s);
      e = 0; bc = 0; s = 1'b0;
      if (dut_if.Busy) bc++;
      while (!s && e < 100) begin
         @(posedge clk);
         #1;
         e++;
         if (dut_if.Done) s = 1'b1;
         else if (dut_if.Busy) bc++;
      end
   endtask

   task automatic count_done(input int cycles, output int n);
      n = 0;
      repeat (cycles) begin
         @(posedge clk);
         #1;
         if (dut_if.Done) n++;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({dut_if.Busy, dut_if.Done, dut_if.DivZero, dut_if.Hi, dut_if.Lo} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h %h busy=%b done=%b dz=%b expected all zero",
                  dut_if.Hi, dut_if.Lo, dut_if.Busy, dut_if.Done, dut_if.DivZero);
      end
      n_cmp++;
      if (dbg_state !== S_IDLE) begin
         n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, S_IDLE);
      end
      rst_n = 1'b1;
      last_exp = '0;
   endtask

   task automatic test_multu();
      issue_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(edges, busy_cyc, seen);
      n_cmp++;
      if (!seen) begin n_fail++; $display("FAIL multu_timeout: no Done within 100 edges"); end
      exp_v = exp_q.pop_front();
      n_cmp++;
      if ({dut_if.Hi, dut_if.Lo} !== exp_v || exp_v !== 64'hFFFF_FFFE_0000_0001) begin
         n_fail++; $display("FAIL multu_result: got %h%h expected %h", dut_if.Hi, dut_if.Lo, exp_v);
      end
      last_exp = exp_v;
      n_cmp++;
      if (edges !== W + 1) begin
         n_fail++; $display("FAIL multu_latency: got %0d edges expected %0d", edges, W + 1);
      end
      n_cmp++;
      if (busy_cyc !== W + 1) begin
         n_fail++; $display("FAIL multu_busy_cycles: got %0d expected %0d", busy_cyc, W + 1);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (dut_if.Done !== 1'b0) begin
         n_fail++; $display("FAIL multu_done_width: got Done=%b expected 0", dut_if.Done);
      end
   endtask

   task automatic test_mult();
      issue_op(2'b00, 32'hFFFF_FFFD, 32'd5);
      wait_done(edges, busy_cyc, seen);
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (!seen || {dut_if.Hi, dut_if.Lo} !== exp_v) begin
         n_fail++; $display("FAIL mult_result: got %h%h expected %h", dut_if.Hi, dut_if.Lo, exp_v);
      end
      last_exp = exp_v;
      n_cmp++;
      if (dut_if.DivZero !== 1'b0) begin
         n_fail++; $display("FAIL mult_divzero: got %b expected 0", dut_if.DivZero);
      end
   endtask

   task automatic test_div();
      logic [W-1:0] as [2];
      logic [W-1:0] bs [2];
      as[0] = 32'hFFFF_FFF9; bs[0] = 32'd2;
      as[1] = 32'h8000_0000; bs[1] = 32'hFFFF_FFFF;
      for (int i = 0; i < 2; i++) begin
         issue_op(2'b10, as[i], bs[i]);
         wait_done(edges, busy_cyc, seen);
         exp_v = exp_q.pop_front();
         n_cmp++;
         if (!seen || {dut_if.Hi, dut_if.Lo} !== exp_v) begin
            n_fail++;
            $display("FAIL div_result_%0d: got %h%h expected %h", i, dut_if.Hi, dut_if.Lo, exp_v);
         end
         last_exp = exp_v;
      end
   endtask

   task automatic test_divzero();
      issue_op(2'b11, 32'd10, 32'd0);
      wait_done(edges, busy_cyc, seen);
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (!seen || edges !== 1) begin
         n_fail++; $display("FAIL divzero_latency: got %0d edges (seen=%b) expected 1", edges, seen);
      end
      n_cmp++;
      if (busy_cyc !== 1) begin
         n_fail++; $display("FAIL divzero_busy: got %0d cycles expected 1", busy_cyc);
      end
      n_cmp++;
      if ({dut_if.Hi, dut_if.Lo} !== exp_v || dut_if.DivZero !== 1'b1) begin
         n_fail++;
         $display("FAIL divzero_result: got %h%h dz=%b expected %h dz=1",
                  dut_if.Hi, dut_if.Lo, dut_if.DivZero, exp_v);
      end
      issue_op(2'b01, 32'd2, 32'd3);
      n_cmp++;
      if (dut_if.DivZero !== 1'b0) begin
         n_fail++; $display("FAIL divzero_clear: got %b expected 0", dut_if.DivZero);
      end
      wait_done(edges, busy_cyc, seen);
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (!seen || {dut_if.Hi, dut_if.Lo} !== exp_v) begin
         n_fail++; $display("FAIL multu_small: got %h%h expected %h", dut_if.Hi, dut_if.Lo, exp_v);
      end
      last_exp = exp_v;
   endtask

   task automatic test_direct_write();
      @(negedge clk);
      dut_if.HiWrite = 1'b1; dut_if.WrData = 32'h0000_1234;
      @(posedge clk); #1;
      dut_if.HiWrite = 1'b0;
      n_cmp++;
      if ({dut_if.Hi, dut_if.Lo} !== {32'h0000_1234, last_exp[W-1:0]}) begin
         n_fail++; $display("FAIL mthi: got %h%h expected %h%h", dut_if.Hi, dut_if.Lo,
                            32'h0000_1234, last_exp[W-1:0]);
      end
      @(negedge clk);
      dut_if.HiWrite = 1'b1; dut_if.LoWrite = 1'b1; dut_if.WrData = 32'hA5A5_5A5A;
      @(posedge clk); #1;
      dut_if.HiWrite = 1'b0; dut_if.LoWrite = 1'b0;
      n_cmp++;
      if ({dut_if.Hi, dut_if.Lo} !== {2{32'hA5A5_5A5A}}) begin
         n_fail++; $display("FAIL mthi_mtlo: got %h%h expected %h", dut_if.Hi, dut_if.Lo,
                            {2{32'hA5A5_5A5A}});
      end
      // Write coinciding with an accepted Start lands at E0, result overwrites later.
      @(negedge clk);
      dut_if.HiWrite = 1'b1; dut_if.WrData = 32'h0000_BEEF;
      dut_if.Start = 1'b1; dut_if.Op = 2'b01; dut_if.A = 32'd7; dut_if.B = 32'd9;
      exp_q.push_back(model(2'b01, 32'd7, 32'd9));
      @(posedge clk); #1;
      dut_if.HiWrite = 1'b0; dut_if.Start = 1'b0;
      n_cmp++;
      if (dut_if.Hi !== 32'h0000_BEEF || dut_if.Busy !== 1'b1) begin
         n_fail++; $display("FAIL write_with_start: got Hi=%h busy=%b expected Hi=0000beef busy=1",
                            dut_if.Hi, dut_if.Busy);
      end
      wait_done(edges, busy_cyc, seen);
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (!seen || {dut_if.Hi, dut_if.Lo} !== exp_v) begin
         n_fail++; $display("FAIL write_then_op: got %h%h expected %h", dut_if.Hi, dut_if.Lo, exp_v);
      end
      last_exp = exp_v;
   endtask

   task automatic test_busy_ignores();
      issue_op(2'b01, 32'h0000_1000, 32'd3);
      repeat (4) @(posedge clk);
      @(negedge clk);
      dut_if.HiWrite = 1'b1; dut_if.LoWrite = 1'b1; dut_if.WrData = 32'hDEAD_0000;
      dut_if.Start = 1'b1; dut_if.Op = 2'b11; dut_if.A = 32'd1; dut_if.B = 32'd0;
      @(posedge clk); #1;
      dut_if.HiWrite = 1'b0; dut_if.LoWrite = 1'b0; dut_if.Start = 1'b0;
      n_cmp++;
      if ({dut_if.Hi, dut_if.Lo} !== last_exp) begin
         n_fail++; $display("FAIL busy_write_ignored: got %h%h expected %h",
                            dut_if.Hi, dut_if.Lo, last_exp);
      end
      wait_done(edges, busy_cyc, seen);
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (!seen || {dut_if.Hi, dut_if.Lo} !== exp_v || dut_if.DivZero !== 1'b0) begin
         n_fail++; $display("FAIL busy_start_result: got %h%h dz=%b expected %h dz=0",
                            dut_if.Hi, dut_if.Lo, dut_if.DivZero, exp_v);
      end
      last_exp = exp_v;
      count_done(40, n_done);
      n_cmp++;
      if (n_done !== 0) begin
         n_fail++; $display("FAIL busy_start_single_done: got %0d extra Done expected 0", n_done);
      end
   endtask

   task automatic test_abort();
      issue_op(2'b01, 32'h0001_2345, 32'h0000_6789);
      repeat (9) @(posedge clk);
      @(negedge clk);
      dut_if.Abort = 1'b1;
      @(posedge clk); #1;
      dut_if.Abort = 1'b0;
      void'(exp_q.pop_back());
      n_cmp++;
      if (dut_if.Busy !== 1'b0 || dbg_state !== S_IDLE) begin
         n_fail++; $display("FAIL abort_busy: got busy=%b state=%0d expected busy=0 state=0",
                            dut_if.Busy, dbg_state);
      end
      n_cmp++;
      if ({dut_if.Hi, dut_if.Lo} !== last_exp) begin
         n_fail++; $display("FAIL abort_hilo: got %h%h expected %h", dut_if.Hi, dut_if.Lo, last_exp);
      end
      count_done(40, n_done);
      n_cmp++;
      if (n_done !== 0) begin
         n_fail++; $display("FAIL abort_no_done: got %0d Done pulses expected 0", n_done);
      end
   endtask

   // Each Start is driven in the cycle where Done is still high.
   task automatic test_back_to_back();
      logic [1:0]   op;
      logic [W-1:0] a, b;
      for (int i = 0; i < 12; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         b  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 5)) : W'($urandom);
         if (i == 0) begin op = 2'b11; b = 32'd0; end
         issue_op(op, a, b);
         wait_done(edges, busy_cyc, seen);
         exp_v = exp_q.pop_front();
         n_cmp++;
         if (!seen || {dut_if.Hi, dut_if.Lo} !== exp_v) begin
            n_fail++; $display("FAIL b2b_result_%0d: op=%0d a=%h b=%h got %h%h expected %h",
                               i, op, a, b, dut_if.Hi, dut_if.Lo, exp_v);
         end
         n_cmp++;
         if (dut_if.DivZero !== (op[1] && (b == '0))) begin
            n_fail++; $display("FAIL b2b_divzero_%0d: got %b expected %b", i, dut_if.DivZero,
                               op[1] && (b == '0));
         end
         n_cmp++;
         if (edges !== ((op[1] && (b == '0)) ? 1 : W + 1)) begin
            n_fail++; $display("FAIL b2b_latency_%0d: got %0d edges", i, edges);
         end
         last_exp = exp_v;
      end
   endtask

   task automatic test_async_reset();
      issue_op(2'b10, 32'hFFFF_FF9C, 32'd7);
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      void'(exp_q.pop_back());
      n_cmp++;
      if ({dut_if.Busy, dut_if.Done, dut_if.DivZero, dut_if.Hi, dut_if.Lo} !== '0
          || dbg_state !== S_IDLE) begin
         n_fail++; $display("FAIL async_reset: got %h%h busy=%b state=%0d expected all zero",
                            dut_if.Hi, dut_if.Lo, dut_if.Busy, dbg_state);
      end
      @(negedge clk);
      rst_n = 1'b1;
      n_cmp++;
      if (exp_q.size() !== 0) begin
         n_fail++; $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size());
      end
   endtask

   initial begin
      dut_if.Start = 1'b0; dut_if.Op = 2'b00; dut_if.A = '0; dut_if.B = '0;
      dut_if.Abort = 1'b0; dut_if.HiWrite = 1'b0; dut_if.LoWrite = 1'b0; dut_if.WrData = '0;
      test_reset();
      test_multu();
      test_mult();
      test_div();
      test_divzero();
      test_direct_write();
      test_busy_ignores();
      test_abort();
      test_back_to_back();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
